mazesolver_key_edge_ctrl: RTL and testbench

//  Controller for the active-low push-button inputs (KEY[]) on the SoC Avalon-MM bus.
//  - Synchronises and debounces each key.
//  - Captures press (falling) edges into a sticky register and raises a maskable IRQ.
//  - Replaces the raw level-only PIO read path, so maze-solver software polls or takes interrupts on clean events.

---
 rtl/mazesolver_key_pkg.sv | 12 +
 rtl/mazesolver_key_debounce.sv | 53 +++++
 rtl/mazesolver_key_edge_ctrl.sv | 103 ++++++++++
 tb/tb_mazesolver_key_edge_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mazesolver_key_pkg.sv
// rtl/mazesolver_key_pkg.sv - shared register map and level constants for the key edge controller
package mazesolver_key_pkg;

    localparam logic [1:0] KEY_ADDR_DATA    = 2'd0;
    localparam logic [1:0] KEY_ADDR_RAW     = 2'd1;
    localparam logic [1:0] KEY_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] KEY_ADDR_EDGECAP = 2'd3;

    // Keys are active-low: an idle (unpressed) pin reads high.
    localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/mazesolver_key_debounce.sv
// rtl/mazesolver_key_debounce.sv - one-key synchroniser and debounce counter
module mazesolver_key_debounce
    import mazesolver_key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int CNT_W        = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_sync,
    output logic o_deb,
    output logic o_deb_prev
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_deb;
    logic             r_deb_prev;
    logic [CNT_W-1:0] r_cnt;

    // Synchronise the pin, then accept a new level only after it has held
    // for DEBOUNCE_CYC consecutive cycles; any return to the accepted level
    // restarts the count so short glitches never reach r_deb.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta     <= KEY_RELEASED;
            r_sync     <= KEY_RELEASED;
            r_deb      <= KEY_RELEASED;
            r_deb_prev <= KEY_RELEASED;
            r_cnt      <= '0;
        end else begin
            r_meta     <= i_pin;
            r_sync     <= r_meta;
            r_deb_prev <= r_deb;
            if (r_sync == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sync     = r_sync;
    assign o_deb      = r_deb;
    assign o_deb_prev = r_deb_prev;

endmodule

// File: rtl/mazesolver_key_edge_ctrl.sv
// rtl/mazesolver_key_edge_ctrl.sv - debounced key press capture with maskable IRQ on a register bus
module mazesolver_key_edge_ctrl
    import mazesolver_key_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int CNT_W        = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_deb_prev;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_edgecap_next;
    logic [WIDTH-1:0] w_irqmask_next;
    logic [WIDTH-1:0] w_rd_sel;
    logic [31:0]      w_rd_mux;
    logic             w_wr;
    logic             w_rd;
    logic             w_unused_ok;

    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_irqmask;
    logic [31:0]      r_readdata;
    logic             r_irq;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_key
            mazesolver_key_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC),
                .CNT_W        (CNT_W)
            ) u_debounce (
                .clk        (clk),
                .reset      (reset),
                .i_pin      (in_port[gi]),
                .o_sync     (w_sync[gi]),
                .o_deb      (w_deb[gi]),
                .o_deb_prev (w_deb_prev[gi])
            );
        end
    endgenerate

    // Upper write-data bits beyond WIDTH carry no meaning; fold them away.
    assign w_unused_ok = ^writedata;

    assign w_wr    = chipselect & write;
    assign w_rd    = chipselect & read;
    // A press is the debounced level falling from released to pressed.
    assign w_press = w_deb_prev & ~w_deb;
    assign w_clr   = (w_wr && address == KEY_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // A press in the same cycle as its W1C clear keeps the bit set.
    assign w_edgecap_next = (r_edgecap & ~w_clr) | w_press;
    assign w_irqmask_next = (w_wr && address == KEY_ADDR_IRQMASK) ? writedata[WIDTH-1:0] : r_irqmask;

    // Read mux returns pre-update state and zero-extends to the bus width.
    always_comb begin
        w_rd_sel = '0;
        w_rd_mux = '0;
        case (address)
            KEY_ADDR_DATA:    w_rd_sel = ~w_deb;
            KEY_ADDR_RAW:     w_rd_sel = ~w_sync;
            KEY_ADDR_IRQMASK: w_rd_sel = r_irqmask;
            KEY_ADDR_EDGECAP: w_rd_sel = r_edgecap;
            default:          w_rd_sel = '0;
        endcase
        w_rd_mux[WIDTH-1:0] = w_rd_sel;
    end

    // Register file, registered read data and registered interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edgecap  <= '0;
            r_irqmask  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_edgecap <= w_edgecap_next;
            r_irqmask <= w_irqmask_next;
            r_irq     <= |(w_edgecap_next & w_irqmask_next);
            if (w_rd) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_mazesolver_key_edge_ctrl.sv
// tb/tb_mazesolver_key_edge_ctrl.sv - self-checking bench for the key edge controller
module tb_mazesolver_key_edge_ctrl;

    localparam int WIDTH        = 4;
    localparam int DEBOUNCE_CYC = 16;
    localparam int CNT_W        = 5;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_RAW  = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_ECAP = 2'd3;

    logic             clk = 1'b0;
    logic             reset;
    logic             chipselect;
    logic [1:0]       address;
    logic             read;
    logic             write;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    mazesolver_key_edge_ctrl #(
        .WIDTH        (WIDTH),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = 2'd0;
        writedata  = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) step();
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
        chipselect = 1'b1;
        write      = 1'b1;
        read       = 1'b0;
        address    = addr;
        writedata  = data;
        step();
        bus_idle();
    endtask

    task automatic do_read(input string name, input logic [1:0] addr, input logic [31:0] exp);
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = addr;
        exp_q.push_back(exp);
        step();
        bus_idle();
        chk(name, readdata, exp_q.pop_front());
    endtask

    // Continuous read of one address; sample n expects v_after from n >= thr.
    task automatic mon(input string name, input logic [1:0] addr, input int ncyc,
                       input int thr, input logic [31:0] v_before, input logic [31:0] v_after);
        for (int n = 1; n <= ncyc; n++) begin
            chipselect = 1'b1;
            read       = 1'b1;
            address    = addr;
            exp_q.push_back((n >= thr) ? v_after : v_before);
            step();
            chk($sformatf("%s_c%0d", name, n), readdata, exp_q.pop_front());
        end
        bus_idle();
    endtask

    initial begin
        vecs[0] = '{1'b1, A_MASK, 32'hFFFF_FFFF, 32'h0};
        vecs[1] = '{1'b0, A_MASK, 32'h0,         32'h0000_000F};
        vecs[2] = '{1'b1, A_DATA, 32'hFFFF_FFFF, 32'h0};
        vecs[3] = '{1'b0, A_DATA, 32'h0,         32'h0};
        vecs[4] = '{1'b1, A_RAW,  32'hFFFF_FFFF, 32'h0};
        vecs[5] = '{1'b0, A_RAW,  32'h0,         32'h0};
        vecs[6] = '{1'b1, A_MASK, 32'h0000_0005, 32'h0};
        vecs[7] = '{1'b0, A_MASK, 32'h0,         32'h0000_0005};
        vecs[8] = '{1'b1, A_MASK, 32'h0,         32'h0};
        vecs[9] = '{1'b0, A_ECAP, 32'h0,         32'h0};

        bus_idle();
        in_port = 4'hF;
        reset   = 1'b1;
        wait_cyc(3);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;
        step();
        do_read("rst_data", A_DATA, 32'h0);
        do_read("rst_ecap", A_ECAP, 32'h0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
            end
        end
        chk("vec_irq", {31'd0, irq}, 32'h0);

        // Clean press on key0: debounced level changes 18 cycles after the pin edge.
        in_port[0] = 1'b0;
        mon("press_data", A_DATA, 24, 19, 32'h0, 32'h1);
        do_read("press_ecap", A_ECAP, 32'h1);
        do_read("press_raw", A_RAW, 32'h1);
        in_port[0] = 1'b1;
        mon("release_raw", A_RAW, 4, 3, 32'h1, 32'h0);
        wait_cyc(20);
        do_read("release_data", A_DATA, 32'h0);
        do_write(A_ECAP, 32'h1);
        do_read("release_ecap", A_ECAP, 32'h0);

        // Bouncing key1: 10 low, 3 high, then held low.
        in_port[1] = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            chipselect = 1'b1;
            read       = 1'b1;
            address    = A_ECAP;
            exp_q.push_back((n >= 33) ? 32'h2 : 32'h0);
            step();
            chk($sformatf("bounce_c%0d", n), readdata, exp_q.pop_front());
            if (n == 10) in_port[1] = 1'b1;
            if (n == 13) in_port[1] = 1'b0;
        end
        bus_idle();
        do_read("bounce_data", A_DATA, 32'h2);
        do_write(A_ECAP, 32'hF);

        // Masked IRQ on key2.
        do_write(A_MASK, 32'h4);
        in_port[2] = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            chipselect = 1'b1;
            read       = 1'b1;
            address    = A_ECAP;
            exp_q.push_back((n >= 20) ? 32'h4 : 32'h0);
            step();
            chk($sformatf("irq_ecap_c%0d", n), readdata, exp_q.pop_front());
            chk($sformatf("irq_c%0d", n), {31'd0, irq}, (n >= 19) ? 32'h1 : 32'h0);
        end
        bus_idle();
        do_write(A_ECAP, 32'h4);
        chk("irq_cleared", {31'd0, irq}, 32'h0);
        do_read("irq_ecap_cleared", A_ECAP, 32'h0);

        // W1C of bit3 lands on the same edge that key3's press is captured.
        in_port[3] = 1'b0;
        wait_cyc(18);
        do_write(A_ECAP, 32'h8);
        do_read("collide_ecap", A_ECAP, 32'h8);
        chk("collide_irq", {31'd0, irq}, 32'h0);

        // Reset while key0's counter is at 10; all keys held low through reset.
        do_write(A_ECAP, 32'hF);
        in_port[0] = 1'b0;
        wait_cyc(12);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        mon("midrst_data", A_DATA, 24, 19, 32'h0, 32'hF);
        do_read("midrst_ecap", A_ECAP, 32'hF);
        do_read("midrst_mask", A_MASK, 32'h0);
        chk("midrst_irq", {31'd0, irq}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
